// File: rtl/fifo_reader_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream.
// The master modport is the reader's view and the slave modport is the environment's view.
interface fifo_reader_if #(
   parameter int FIFO_WIDTH = 16
);
   logic                  fifo_empty;
   logic                  fifo_almostempty;
   logic [FIFO_WIDTH-1:0] fifo_dout;
   logic                  fifo_underflow;
   logic                  fifo_rd_en;
   logic [FIFO_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   modport master (
      input  fifo_empty,
      input  fifo_almostempty,
      input  fifo_dout,
      input  fifo_underflow,
      input  m_ready,
      output fifo_rd_en,
      output m_data,
      output m_valid
   );

   modport slave (
      output fifo_empty,
      output fifo_almostempty,
      output fifo_dout,
      output fifo_underflow,
      output m_ready,
      input  fifo_rd_en,
      input  m_data,
      input  m_valid
   );
endinterface

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO into a 2-entry skid buffer that feeds a valid/ready stream.
// Reads are credit-limited, and words returned with fifo_underflow are dropped and counted.
module fifo_reader #(
   parameter int FIFO_WIDTH = 16,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_reader_if.master        bus,
   output logic [ERR_CNT_W-1:0] underflow_cnt,
   output logic                 err
);

   localparam logic [1:0]           OCC_EMPTY = 2'd0;
   localparam logic [1:0]           OCC_ONE   = 2'd1;
   localparam logic [1:0]           OCC_FULL  = 2'd2;
   localparam logic [ERR_CNT_W-1:0] CNT_ONE   = ERR_CNT_W'(1);

   logic [1:0]            occ_q, occ_d;
   logic                  infl_q, infl_d;
   logic [FIFO_WIDTH-1:0] head_q, head_d;
   logic [FIFO_WIDTH-1:0] tail_q, tail_d;
   logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic                  rd_en;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // Words already buffered plus the one in flight, minus the one leaving now, must stay below 2.
   function automatic logic has_credit(input logic [1:0] occ, input logic infl, input logic pop_now);
      logic [2:0] pending;
      pending = {1'b0, occ} + {2'b00, infl} - {2'b00, pop_now};
      return pending < 3'd2;
   endfunction

   always_comb begin
      pop   = (occ_q != OCC_EMPTY) && bus.m_ready;
      push  = infl_q && !bus.fifo_underflow;
      drop  = infl_q && bus.fifo_underflow;
      rd_en = rst_n && !bus.fifo_empty && has_credit(occ_q, infl_q, pop);
   end

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      infl_d = rd_en;
      unique case ({push, pop})
         2'b10: begin
            if (occ_q == OCC_EMPTY) head_d = bus.fifo_dout;
            else                    tail_d = bus.fifo_dout;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            if (occ_q == OCC_FULL) head_d = tail_q;
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            // The departing head is replaced in order; the newcomer goes behind any tail.
            if (occ_q == OCC_ONE) begin
               head_d = bus.fifo_dout;
            end else begin
               head_d = tail_q;
               tail_d = bus.fifo_dout;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (drop) begin
         cnt_d = sat_inc(cnt_q);
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q  <= OCC_EMPTY;
         infl_q <= 1'b0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         infl_q <= infl_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ_q != OCC_EMPTY);
   assign bus.m_data     = head_q;
   assign underflow_cnt  = cnt_q;
   assign err            = err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO and a stream scoreboard are checked every cycle,
// with a scenario table and hand-written timing sequences on top.
module tb_fifo_reader;
   localparam int W       = 16;
   localparam int EW      = 8;
   localparam int CNT_MAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [EW-1:0] underflow_cnt;
   logic          err;

   fifo_reader_if #(.FIFO_WIDTH(W)) bus ();

   fifo_reader #(.FIFO_WIDTH(W), .ERR_CNT_W(EW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.master),
      .underflow_cnt (underflow_cnt),
      .err           (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] fq[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] popped[$];
   logic [W-1:0] d_log[$];
   bit           rd_log[$];
   bit           v_log[$];
   bit           ae_log[$];

   int  uf_total, reads, uf_idx, uf_pct, wr_pct, rdy_pct;
   bit  infl_m, uf_all, rand_rdy, prev_hold, armed;
   logic [W-1:0] prev_d;

   typedef struct {
      int nwords;
      int stall;
      int uf_at;
      int exp_pops;
      int exp_cnt;
      bit exp_err;
      int exp_third;
   } scen_t;

   scen_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int sat(input int n);
      return (n > CNT_MAX) ? CNT_MAX : n;
   endfunction

   function automatic logic [31:0] vec_of(input bit q[$], input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n && i < q.size(); i++) v[i] = q[i];
      return v;
   endfunction

   task automatic upd_flags();
      bus.fifo_empty       = (fq.size() == 0);
      bus.fifo_almostempty = (fq.size() == 1);
   endtask

   task automatic step();
      bit           rd, pop, rst_s, uf_s, exp_rd;
      logic         v;
      logic [W-1:0] d, dout_s;
      int           credit;
      @(negedge clk);
      rst_s  = rst_n;
      rd     = bus.fifo_rd_en;
      v      = bus.m_valid;
      d      = bus.m_data;
      pop    = (v === 1'b1) && bus.m_ready;
      uf_s   = bus.fifo_underflow;
      dout_s = bus.fifo_dout;
      if (armed) begin
         credit = exp_q.size() + int'(infl_m) - int'(pop);
         exp_rd = rst_s && !bus.fifo_empty && (credit < 2);
         chk("rd_en", rd, exp_rd);
         chk("m_valid", v, exp_q.size() != 0);
         if (v === 1'b1 && exp_q.size() != 0) chk("m_data", d, exp_q[0]);
         chk("underflow_cnt", underflow_cnt, sat(uf_total));
         chk("err", err, uf_total != 0);
         if (prev_hold) begin
            chk("hold_valid", v, 1);
            chk("hold_data", d, prev_d);
         end
      end
      prev_hold = armed && rst_s && (v === 1'b1) && !bus.m_ready;
      prev_d    = d;
      rd_log.push_back(rd);
      v_log.push_back(v === 1'b1);
      d_log.push_back(d);
      ae_log.push_back(bus.fifo_almostempty);

      @(posedge clk);
      #1;
      armed = 1'b1;
      if (!rst_s) begin
         exp_q.delete();
         uf_total = 0;
         infl_m   = 1'b0;
      end else begin
         if (pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            popped.push_back(d);
         end
         if (infl_m) begin
            if (uf_s) uf_total++;
            else      exp_q.push_back(dout_s);
         end
         chk("buffer_overflow", exp_q.size() <= 2, 1);
         infl_m = rd;
      end
      if (rd) begin
         chk("read_while_empty", fq.size() != 0, 1);
         reads++;
         if (fq.size() != 0) bus.fifo_dout = fq.pop_front();
         bus.fifo_underflow = uf_all || (reads == uf_idx) || ($urandom_range(0, 99) < uf_pct);
      end else begin
         bus.fifo_underflow = 1'b0;
      end
      if ($urandom_range(0, 99) < wr_pct) fq.push_back(W'($urandom));
      if (rand_rdy) bus.m_ready = ($urandom_range(0, 99) < rdy_pct);
      upd_flags();
   endtask

   task automatic clear_logs();
      rd_log.delete();
      v_log.delete();
      d_log.delete();
      ae_log.delete();
      popped.delete();
      reads = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic load(input int n, input int base);
      for (int i = 0; i < n; i++) fq.push_back(W'(base + i));
      upd_flags();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      rand_rdy    = 1'b0;
      wr_pct      = 0;
      bus.m_ready = 1'b1;
      while ((fq.size() != 0 || exp_q.size() != 0 || infl_m) && n < 2000) begin
         step();
         n++;
      end
      chk({name, "_drain_timeout"}, n < 2000, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ae_reads, base;
      tbl[0] = '{1, 0,  0, 1, 0, 1'b0, 0};
      tbl[1] = '{8, 0,  0, 8, 0, 1'b0, 3};
      tbl[2] = '{5, 10, 0, 5, 0, 1'b0, 3};
      tbl[3] = '{5, 0,  3, 4, 1, 1'b1, 4};
      tbl[4] = '{6, 4,  2, 5, 1, 1'b1, 4};
      tbl[5] = '{3, 2,  1, 2, 1, 1'b1, 0};

      rst_n = 1'b0;
      bus.m_ready = 1'b0;
      bus.fifo_dout = '0;
      bus.fifo_underflow = 1'b0;
      uf_total = 0; reads = 0; uf_idx = 0; uf_pct = 0; wr_pct = 0; rdy_pct = 0;
      infl_m = 1'b0; uf_all = 1'b0; rand_rdy = 1'b0; prev_hold = 1'b0; armed = 1'b0;
      upd_flags();

      // Reset with words already waiting in the FIFO: no read may issue.
      step();
      load(2, 16'h7001);
      step();
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_cnt", underflow_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_en", bus.fifo_rd_en, 0);
      rst_n = 1'b1;
      drain("init");

      // Single word: read pulse in t, valid in t+2 for one cycle.
      clear_logs();
      bus.m_ready = 1'b1;
      load(1, 16'hA5A5);
      repeat (6) step();
      chk("single_rd", vec_of(rd_log, 6), 32'b000001);
      chk("single_valid", vec_of(v_log, 6), 32'b000100);
      chk("single_data", d_log[2], 16'hA5A5);

      // Streaming: 8 back-to-back reads, 8 back-to-back outputs.
      clear_logs();
      load(8, 1);
      repeat (12) step();
      chk("stream_rd", vec_of(rd_log, 12), 32'h0FF);
      chk("stream_valid", vec_of(v_log, 12), 32'h3FC);
      for (int i = 0; i < 8; i++) chk("stream_data", d_log[2 + i], i + 1);
      ae_reads = 0;
      for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] && ae_log[i]) ae_reads++;
      chk("stream_last_word_reads", ae_reads, 1);
      chk("stream_cnt", underflow_cnt, 0);

      // Backpressure: two reads during the stall, head stays on word 1.
      clear_logs();
      bus.m_ready = 1'b0;
      load(5, 1);
      repeat (10) step();
      n = 0;
      for (int i = 0; i < rd_log.size(); i++) if (rd_log[i]) n++;
      chk("bp_stall_reads", n, 2);
      chk("bp_occ", dut.occ_q, 2);
      chk("bp_valid", bus.m_valid, 1);
      chk("bp_head", bus.m_data, 1);
      drain("bp");
      chk("bp_count", popped.size(), 5);
      for (int i = 0; i < 5 && i < popped.size(); i++) chk("bp_order", popped[i], i + 1);

      // Scenario table: delivered count, error counter and ordering after drops.
      for (int k = 0; k < 6; k++) begin
         do_reset();
         clear_logs();
         base   = 16'h0100 * (k + 1);
         uf_idx = tbl[k].uf_at;
         bus.m_ready = (tbl[k].stall == 0);
         load(tbl[k].nwords, base);
         repeat (tbl[k].stall) step();
         drain("tbl");
         uf_idx = 0;
         chk("tbl_pops", popped.size(), tbl[k].exp_pops);
         chk("tbl_cnt", underflow_cnt, tbl[k].exp_cnt);
         chk("tbl_err", err, tbl[k].exp_err);
         if (tbl[k].exp_third != 0 && popped.size() > 2)
            chk("tbl_third", popped[2], base + tbl[k].exp_third - 1);
      end

      // Counter saturation: 300 dropped words.
      do_reset();
      clear_logs();
      uf_all = 1'b1;
      bus.m_ready = 1'b1;
      load(300, 0);
      drain("sat");
      uf_all = 1'b0;
      chk("sat_cnt", underflow_cnt, 255);
      chk("sat_err", err, 1);
      chk("sat_pops", popped.size(), 0);

      // Reset mid-stream with a full buffer and a nonzero error count.
      do_reset();
      clear_logs();
      uf_idx = 1;
      bus.m_ready = 1'b0;
      load(6, 16'h0C01);
      n = 0;
      while (exp_q.size() < 2 && n < 20) begin
         step();
         n++;
      end
      chk("mid_reach_full", n < 20, 1);
      chk("mid_occ", dut.occ_q, 2);
      chk("mid_pre_cnt", underflow_cnt, 1);
      uf_idx = 0;
      bus.m_ready = 1'b1;
      rst_n = 1'b0;
      step();
      chk("mid_rd_in_reset", rd_log[rd_log.size() - 1], 0);
      chk("mid_valid", bus.m_valid, 0);
      chk("mid_cnt", underflow_cnt, 0);
      chk("mid_err", err, 0);
      rst_n = 1'b1;
      step();
      chk("mid_resume_rd", rd_log[rd_log.size() - 1], 1);
      drain("mid");
      chk("mid_count", popped.size(), 3);
      if (popped.size() > 0) chk("mid_first", popped[0], 16'h0C04);

      // Randomized traffic, stalls, drops and occasional resets.
      do_reset();
      clear_logs();
      rand_rdy = 1'b1;
      rdy_pct  = 60;
      wr_pct   = 50;
      uf_pct   = 8;
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n  = 1'b1;
      uf_pct = 0;
      drain("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the synchronous FIFO. It drains words from the FIFO read port and presents them on a valid/ready output stream through a 2-entry skid buffer, and it never issues a read while the FIFO reports empty. It sits between the FIFO and the downstream consumer, such as the SPI/RAM command path. It also counts FIFO underflow indications as protocol errors.

## Interface
- FIFO_WIDTH, 16, data word width.
- ERR_CNT_W, 8, width of the saturating underflow error counter.

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag (registered in FIFO).
- fifo_almostempty  input  1  FIFO holds exactly one word.
- fifo_dout  input  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_underflow  input  1  FIFO underflow flag; sampled the cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO read strobe.
- m_data  output  FIFO_WIDTH  output stream data, the head of the skid buffer.
- m_valid  output  1  m_data holds a word.
- m_ready  input  1  consumer accepts the word when m_valid && m_ready.
- underflow_cnt  output  ERR_CNT_W  number of reads answered with fifo_underflow; saturates.
- err  output  1  sticky; set on the first underflow; cleared only by reset.

## Operation
- **State:** skid occupancy occ ∈ {0,1,2}, plus an in-flight bit infl set when a read was issued last cycle.
- **Pop:** pop = m_valid && m_ready.
- **Read issue (combinational):** fifo_rd_en = rst_n && !fifo_empty && (occ + infl − pop) < 2.
  - This credit rule guarantees the buffer never overflows.
  - fifo_rd_en is never high while fifo_empty = 1.
- **Capture:** when infl = 1, fifo_dout is the returned word.
  - If fifo_underflow = 0: push fifo_dout into the skid buffer.
  - If fifo_underflow = 1: discard the word, increment underflow_cnt (saturating at all-ones) and set err.
- **Skid buffer:** 2-entry, in order.
  - Push into an empty buffer, or into a buffer popping its only entry, loads the head.
  - Otherwise a push loads the tail.
  - Pop shifts tail to head.
  - Push and pop in the same cycle leave occ unchanged.
- **Occupancy transitions:**
  - 0→1 on push.
  - 1→2 on push without pop.
  - 2→1 on pop without push.
  - 1→0 on pop without push.
  - Push with pop holds occ.
  - Push at occ = 2 is impossible by the credit rule; the verification engineer asserts it.
- **Outputs:** m_valid = (occ != 0). m_data = head.
- **Stream rules:**
  - m_valid never depends on m_ready.
  - While m_valid && !m_ready, m_data and m_valid hold stable.
- **Reset (rst_n low at an edge):**
  - occ = 0, infl = 0, m_valid = 0, m_data = 0, underflow_cnt = 0, err = 0.
  - fifo_rd_en = 0 throughout the reset cycle.
  - Any in-flight word returned after reset is ignored.

## Timing
- **Latency:** FIFO goes non-empty in cycle t → fifo_rd_en in t → word captured at the end of t+1 → m_valid in t+2.
- **Throughput:** with m_ready held at 1, one word per cycle sustained (steady state occ = 1, infl = 1).
- **Backpressure:** with m_ready = 0, at most 2 more reads issue, then fifo_rd_en stays low until a pop.
- **Last word:** a read with fifo_almostempty = 1 is legal. The next cycle fifo_empty = 1 and no further read issues.
- **Reset mid-stream:** buffered and in-flight words are lost. The first post-reset read issues in the first cycle with rst_n high and fifo_empty = 0.
- **Counter:** underflow_cnt updates in the capture cycle (t+1), visible at t+2.

## Test plan
- **Single word:** preload the FIFO with 0xA5A5, m_ready = 1.
  - Expect exactly one fifo_rd_en pulse.
  - Expect m_valid for 1 cycle with m_data = 0xA5A5, two cycles after the pulse.
  - Expect no read while empty.
- **Streaming:** preload 8 words 0x0001..0x0008, m_ready = 1.
  - Expect 8 consecutive fifo_rd_en pulses.
  - Expect outputs in order on 8 consecutive cycles.
  - Expect underflow_cnt = 0.
- **Backpressure:** preload 5 words, m_ready = 0 for 10 cycles, then 1.
  - Expect exactly 2 reads during the stall, occ = 2, m_data stable at word 1.
  - After release, expect all 5 words in order with none lost or duplicated.
- **Injected underflow:** force fifo_underflow = 1 in the capture cycle of the 3rd word.
  - Expect that word dropped, underflow_cnt = 1 and err = 1.
  - Expect the remaining words delivered normally.
- **Counter saturation:** inject 300 underflows with ERR_CNT_W = 8 → expect underflow_cnt = 255.
- **Reset mid-stream:** assert rst_n = 0 for 1 cycle while occ = 2.
  - Expect m_valid = 0, underflow_cnt = 0, err = 0 and fifo_rd_en = 0 in the reset cycle.
  - Expect reads to resume the next cycle if the FIFO is non-empty.
